button_io_port: RTL and testbench

BUTTON_IO_PORT -- requirements
Module: button_io_port

---
 rtl/button_io_port.sv | 94 +++++++++
 tb/tb_button_io_port.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_io_port.sv
// rtl/button_io_port.sv - debounced two-button status port on the CPU data bus
//
// Two active-low board buttons are synchronized, debounced and presented
// as an active-high level plus a sticky press flag per button. The CPU reads
// {12'b0, press[1:0], level[1:0]} at PORT_ADDR; reading clears the press flags.
//
// Ports:
//   clk     - single clock, all state on rising edge
//   res     - asynchronous reset, active-low
//   btn     - raw buttons, active-low, asynchronous and bouncing
//   sel     - data-bus chip select
//   ld      - 1 = read cycle, 0 = write cycle
//   addr    - data address
//   dataOut - registered read data (zero unless this port was read)
//   hit     - registered; 1 when dataOut carries this port's data
//   level   - debounced button state, active-high

module button_io_port #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [11:0] PORT_ADDR       = 12'd111
) (
  input  logic        clk,
  input  logic        res,
  input  logic [1:0]  btn,
  input  logic        sel,
  input  logic        ld,
  input  logic [11:0] addr,
  output logic [15:0] dataOut,
  output logic        hit,
  output logic [1:0]  level
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Inversion is folded in front of the first flop so that the reset value
  // of the synchronizer (0) means "not pressed".
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0][15:0] cnt;
  logic [1:0]       press;
  logic [1:0]       level_nxt;
  logic             rd;

  assign rd = sel & ld & (addr == PORT_ADDR);

  // A button is accepted on the edge where its counter has already seen
  // DEBOUNCE_CYCLES-1 differing cycles and the input still differs.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < 2; i++) begin
      if ((sync2[i] != level[i]) && (cnt[i] == CNT_LAST)) begin
        level_nxt[i] = sync2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1   <= '0;
      sync2   <= '0;
      cnt     <= '0;
      level   <= '0;
      press   <= '0;
      dataOut <= '0;
      hit     <= 1'b0;
    end else begin
      sync1 <= ~btn;
      sync2 <= sync1;

      // Clearing on acceptance keeps the counter from ever wrapping.
      for (int i = 0; i < 2; i++) begin
        if ((sync2[i] == level[i]) || (cnt[i] == CNT_LAST)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end

      level <= level_nxt;

      // A rising edge on the same cycle as a clearing read wins.
      press <= (press & ~{2{rd}}) | (level_nxt & ~level);

      if (rd) begin
        dataOut <= {12'b0, press, level};
        hit     <= 1'b1;
      end else begin
        dataOut <= '0;
        hit     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_io_port.sv
// tb/tb_button_io_port.sv - scoreboard bench for button_io_port

module tb_button_io_port;

  logic        clk;
  logic        res;
  logic [1:0]  btn;
  logic        sel;
  logic        ld;
  logic [11:0] addr;
  logic [15:0] dataOut;
  logic        hit;
  logic [1:0]  level;

  int total = 0;
  int bad   = 0;

  logic        probe   = 1'b0;
  logic        probe_d = 1'b0;
  logic [16:0] exp_q[$];

  button_io_port #(
    .DEBOUNCE_CYCLES(4),
    .PORT_ADDR(12'd111)
  ) dut (
    .clk(clk),
    .res(res),
    .btn(btn),
    .sel(sel),
    .ld(ld),
    .addr(addr),
    .dataOut(dataOut),
    .hit(hit),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: the cycle after a probed bus access, pop the expected response.
  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("bus_dataOut", {16'h0, dataOut}, {16'h0, e[15:0]});
        chk("bus_hit", {31'h0, hit}, {31'h0, e[16]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic access(input logic s, input logic l, input logic [11:0] a,
                        input logic [15:0] exp_data, input logic exp_hit);
    @(negedge clk);
    sel   = s;
    ld    = l;
    addr  = a;
    probe = 1'b1;
    exp_q.push_back({exp_hit, exp_data});
    @(negedge clk);
    sel   = 1'b0;
    ld    = 1'b0;
    addr  = 12'd0;
    probe = 1'b0;
  endtask

  task automatic rd111(input logic [15:0] exp_data);
    access(1'b1, 1'b1, 12'd111, exp_data, 1'b1);
  endtask

  initial begin
    res  = 1'b1;
    btn  = 2'b11;
    sel  = 1'b0;
    ld   = 1'b0;
    addr = 12'd0;
    #2 res = 1'b0;
    step(3);
    chk("reset_level", {30'h0, level}, 32'h0);
    chk("reset_dataOut", {16'h0, dataOut}, 32'h0);
    chk("reset_hit", {31'h0, hit}, 32'h0);
    res = 1'b1;
    step(2);

    // Button0 press: accepted exactly 6 cycles after the raw change.
    btn = 2'b10;
    step(5);
    chk("b0_level_early", {30'h0, level}, 32'h0);
    step(1);
    chk("b0_level_accept", {30'h0, level}, 32'h1);
    rd111(16'h0005);
    rd111(16'h0001);
    btn = 2'b11;
    step(8);
    chk("b0_level_release", {30'h0, level}, 32'h0);
    rd111(16'h0000);

    // 3-cycle glitch rejected.
    btn = 2'b10;
    step(3);
    btn = 2'b11;
    step(10);
    chk("glitch3_level", {30'h0, level}, 32'h0);
    rd111(16'h0000);

    // 4-cycle pulse is just long enough to be accepted.
    btn = 2'b10;
    step(4);
    btn = 2'b11;
    step(2);
    chk("pulse4_level", {30'h0, level}, 32'h1);
    step(10);
    chk("pulse4_level_after", {30'h0, level}, 32'h0);
    rd111(16'h0004);

    // Both pressed; non-matching accesses return zero and leave flags alone.
    btn = 2'b00;
    step(6);
    chk("both_level", {30'h0, level}, 32'h3);
    access(1'b1, 1'b1, 12'd110, 16'h0000, 1'b0);
    access(1'b1, 1'b0, 12'd111, 16'h0000, 1'b0);
    access(1'b0, 1'b1, 12'd111, 16'h0000, 1'b0);
    rd111(16'h000F);
    rd111(16'h0003);
    btn = 2'b11;
    step(8);
    chk("both_release", {30'h0, level}, 32'h0);

    // Read lands on the very edge button1 is accepted: set wins over clear.
    btn = 2'b01;
    step(4);
    rd111(16'h0000);
    chk("race_level", {30'h0, level}, 32'h2);
    rd111(16'h000A);
    btn = 2'b11;
    step(8);
    rd111(16'h0000);

    // Reset mid-debounce, buttons held through release.
    btn = 2'b10;
    step(8);
    chk("pre_reset_level", {30'h0, level}, 32'h1);
    btn = 2'b00;
    step(2);
    #1 res = 1'b0;
    #1;
    chk("async_reset_level", {30'h0, level}, 32'h0);
    chk("async_reset_dataOut", {16'h0, dataOut}, 32'h0);
    chk("async_reset_hit", {31'h0, hit}, 32'h0);
    step(1);
    res = 1'b1;
    step(5);
    chk("post_reset_early", {30'h0, level}, 32'h0);
    step(1);
    chk("post_reset_accept", {30'h0, level}, 32'h3);
    rd111(16'h000F);
    btn = 2'b11;
    step(8);
    rd111(16'h0000);

    // Fast toggling never settles.
    for (int i = 0; i < 10; i++) begin
      btn = 2'b10;
      step(2);
      btn = 2'b11;
      step(2);
      chk("toggle_level", {30'h0, level}, 32'h0);
    end
    btn = 2'b10;
    step(5);
    chk("toggle_hold_early", {30'h0, level}, 32'h0);
    step(1);
    chk("toggle_hold_accept", {30'h0, level}, 32'h1);
    rd111(16'h0005);

    step(3);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
